// File: rtl/anthem_text_sequencer_if.sv
// Control, ROM and character-stream signals of the anthem text sequencer.
interface anthem_text_sequencer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned MSG_W  = 2,
  parameter int unsigned DIV_W  = 8
);
  // Run control from the switch inputs
  logic              start;
  logic              stop;
  logic [MSG_W-1:0]  msg_sel;
  logic              loop_en;
  logic [DIV_W-1:0]  div;

  // Character ROM bus (1-cycle synchronous read)
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;

  // Character stream towards the display stage
  logic [7:0]        char_out;
  logic              char_valid;
  logic              char_ready;

  // Status
  logic              busy;
  logic              done;

  // Sequencer side: owns the ROM address and sources the character stream
  modport master (
    input  start, stop, msg_sel, loop_en, div, rom_data, char_ready,
    output rom_addr, char_out, char_valid, busy, done
  );

  // Environment side: switches, ROM and character consumer
  modport slave (
    output start, stop, msg_sel, loop_en, div, rom_data, char_ready,
    input  rom_addr, char_out, char_valid, busy, done
  );
endinterface

// File: rtl/anthem_text_sequencer.sv
// Sequences the character ROM: pointer lookup, byte fetch, paced character stream.
module anthem_text_sequencer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned MSG_W  = 2,
  parameter int unsigned DIV_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  anthem_text_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PTR_REQ,
    S_PTR_CAP,
    S_CH_REQ,
    S_CH_CAP,
    S_EMIT,
    S_GAP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  gap_cnt;

  logic              xfer_c;
  logic              eom_c;

  // Stream handshake and end-of-message detection (terminator or last ROM byte)
  always_comb begin
    xfer_c = bus.char_valid & bus.char_ready;
    eom_c  = ((state == S_CH_CAP) && (bus.rom_data == 8'h00)) ||
             ((state == S_EMIT) && xfer_c && (bus.rom_addr == ADDR_LAST));
  end

  // Sequencer FSM with registered outputs; stop overrides everything outside IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      bus.rom_addr   <= '0;
      bus.char_out   <= 8'h00;
      bus.char_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      base_q         <= '0;
      div_q          <= '0;
      gap_cnt        <= '0;
    end else begin
      bus.done <= 1'b0;
      if (bus.stop && (state != S_IDLE)) begin
        state          <= S_IDLE;
        bus.char_valid <= 1'b0;
        bus.busy       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start && !bus.stop) begin
              bus.rom_addr <= ADDR_W'(bus.msg_sel);
              div_q        <= bus.div;
              bus.busy     <= 1'b1;
              state        <= S_PTR_REQ;
            end
          end
          S_PTR_REQ: state <= S_PTR_CAP;
          S_PTR_CAP: begin
            base_q       <= ADDR_W'(bus.rom_data);
            bus.rom_addr <= ADDR_W'(bus.rom_data);
            state        <= S_CH_REQ;
          end
          S_CH_REQ: state <= S_CH_CAP;
          S_CH_CAP: begin
            if (bus.rom_data != 8'h00) begin
              bus.char_out   <= bus.rom_data;
              bus.char_valid <= 1'b1;
              state          <= S_EMIT;
            end
          end
          S_EMIT: begin
            if (xfer_c) begin
              bus.char_valid <= 1'b0;
              // The last ROM address ends the message instead of wrapping
              if (bus.rom_addr != ADDR_LAST) begin
                bus.rom_addr <= bus.rom_addr + ADDR_W'(1);
                if (div_q == '0) begin
                  state <= S_CH_REQ;
                end else begin
                  gap_cnt <= div_q;
                  state   <= S_GAP;
                end
              end
            end
          end
          S_GAP: begin
            gap_cnt <= gap_cnt - DIV_W'(1);
            if (gap_cnt == DIV_W'(1)) begin
              state <= S_CH_REQ;
            end
          end
          default: state <= S_IDLE;
        endcase

        // End-of-message: pulse done, then replay from the latched base or stop
        if (eom_c) begin
          bus.done <= 1'b1;
          if (bus.loop_en) begin
            bus.rom_addr <= base_q;
            state        <= S_CH_REQ;
          end else begin
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end
        end
      end
    end
  end

endmodule
